// File: rtl/video_timing_pkg.sv
// Shared raster constants, colour codes and the region classifier for the NTSC timing generator.
// The colour codes here match the synthesizer's colour tables.
package video_timing_pkg;

  localparam logic [9:0] H_TOTAL        = 10'd910;
  localparam logic [9:0] H_SYNC         = 10'd67;
  localparam logic [9:0] H_BURST_START  = 10'd76;
  localparam logic [9:0] H_BURST_LEN    = 10'd36;
  localparam logic [9:0] H_ACTIVE_START = 10'd160;
  localparam logic [9:0] H_ACTIVE_LEN   = 10'd640;
  localparam int         PIX_SHIFT      = 2;

  localparam logic [8:0] V_TOTAL        = 9'd262;
  localparam logic [8:0] V_SYNC_START   = 9'd3;
  localparam logic [8:0] V_SYNC_LEN     = 9'd3;
  localparam logic [8:0] V_ACTIVE_START = 9'd40;
  localparam logic [8:0] V_ACTIVE_LEN   = 9'd192;

  localparam logic [7:0] PHASE_INC      = 8'd64;

  localparam logic [5:0] COL_SYNC        = 6'd0;
  localparam logic [5:0] COL_BLANK       = 6'd1;
  localparam logic [5:0] COL_BURST       = 6'd2;
  localparam logic [5:0] COL_FIRST_PIXEL = 6'd3;

  typedef enum logic [1:0] {
    REG_SYNC  = 2'd0,
    REG_BLANK = 2'd1,
    REG_BURST = 2'd2,
    REG_PIXEL = 2'd3
  } region_t;

  // Vsync lines take precedence over everything; they carry broad pulses and no burst.
  function automatic region_t region_of(input logic [9:0] h, input logic [8:0] v);
    region_t r;
    if (v >= V_SYNC_START && v < V_SYNC_START + V_SYNC_LEN)
      r = (h < H_TOTAL - H_SYNC) ? REG_SYNC : REG_BLANK;
    else if (h < H_SYNC)
      r = REG_SYNC;
    else if (h >= H_BURST_START && h < H_BURST_START + H_BURST_LEN)
      r = REG_BURST;
    else if (v >= V_ACTIVE_START && v < V_ACTIVE_START + V_ACTIVE_LEN &&
             h >= H_ACTIVE_START && h < H_ACTIVE_START + H_ACTIVE_LEN)
      r = REG_PIXEL;
    else
      r = REG_BLANK;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_phase_acc.sv
// 8-bit subcarrier NCO: free-running phase accumulator, cleared only by reset.
module video_timing_phase_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] inc,
  output logic [7:0] phase
);

  always_ff @(posedge clk) begin
    if (reset) phase <= 8'd0;
    else       phase <= phase + inc;
  end

endmodule

// File: rtl/video_timing.sv
// NTSC raster generator: H/V counters, two-stage pipeline producing colour_num and phase
// aligned on the same cycle, plus pixel fetch requests to a sync-read frame RAM.
module video_timing
  import video_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       pix_req,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  input  logic [5:0] pix_colour,
  output logic [5:0] colour_num,
  output logic [7:0] phase,
  output logic       line_start,
  output logic       frame_start
);

  // Frame RAM interface: pix_x/pix_y are a valid address only while pix_req=1; the RAM
  // returns pix_colour on the following cycle, with no stall or backpressure.

  logic [9:0] h;
  logic [8:0] v;
  logic [7:0] acc;
  region_t    region_c;

  region_t    region_s1;
  logic [7:0] acc_s1;
  logic       line_s1;
  logic       frame_s1;

  region_t    region_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= 10'd0;
      v <= 9'd0;
    end else if (h == H_TOTAL - 10'd1) begin
      h <= 10'd0;
      v <= (v == V_TOTAL - 9'd1) ? 9'd0 : v + 9'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  video_timing_phase_acc u_phase_acc (
    .clk   (clk),
    .reset (reset),
    .inc   (PHASE_INC),
    .phase (acc)
  );

  assign region_c = region_of(h, v);

  // Stage 1: classify and issue the RAM address; address holds outside active pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_s1 <= REG_SYNC;
      pix_req   <= 1'b0;
      pix_x     <= 8'd0;
      pix_y     <= 8'd0;
      acc_s1    <= 8'd0;
      line_s1   <= 1'b0;
      frame_s1  <= 1'b0;
    end else begin
      region_s1 <= region_c;
      pix_req   <= (region_c == REG_PIXEL);
      if (region_c == REG_PIXEL) begin
        pix_x <= 8'((h - H_ACTIVE_START) >> PIX_SHIFT);
        pix_y <= 8'(v - V_ACTIVE_START);
      end
      acc_s1    <= acc;
      line_s1   <= (h == 10'd0);
      frame_s1  <= (h == 10'd0) && (v == 9'd0);
    end
  end

  // Stage 2: the RAM data arrives this cycle, so the final colour mux is combinational.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_s2   <= REG_SYNC;
      phase       <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      region_s2   <= region_s1;
      phase       <= acc_s1;
      line_start  <= line_s1;
      frame_start <= frame_s1;
    end
  end

  // RAM codes below COL_FIRST_PIXEL would alias sync/blank/burst, so they become blank.
  always_comb begin
    colour_num = COL_BLANK;
    case (region_s2)
      REG_SYNC:  colour_num = COL_SYNC;
      REG_BLANK: colour_num = COL_BLANK;
      REG_BURST: colour_num = COL_BURST;
      REG_PIXEL: colour_num = (pix_colour < COL_FIRST_PIXEL) ? COL_BLANK : pix_colour;
      default:   colour_num = COL_BLANK;
    endcase
  end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: reset behaviour, sync/burst/pixel line shapes, pixel
// fetch addressing through a sync-read RAM model, line/frame pulses and subcarrier phase.
module tb_video_timing;

  logic       clk;
  logic       reset;
  logic       pix_req;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic [5:0] pix_colour;
  logic [5:0] colour_num;
  logic [7:0] phase;
  logic       line_start;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int line_cnt = 0;
  int last_ls  = -1;
  bit mon_en   = 1'b0;
  logic [5:0] ram_q = 6'd0;
  logic [5:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  video_timing dut (
    .clk         (clk),
    .reset       (reset),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
    .colour_num  (colour_num),
    .phase       (phase),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  // Frame RAM model: contents at (x,y) are x[5:0], one cycle read latency.
  always @(posedge clk) if (pix_req) ram_q <= pix_x[5:0];
  assign pix_colour = ram_q;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Hand table of the expected colour for output position (h,v) with the RAM model above.
  function automatic int exp_col(input int h, input int v);
    int x;
    if (v >= 3 && v <= 5) return (h < 843) ? 0 : 1;
    if (h < 67)  return 0;
    if (h < 76)  return 1;
    if (h < 112) return 2;
    if (v >= 40 && v <= 231 && h >= 160 && h <= 799) begin
      x = ((h - 160) / 4) % 64;
      return (x < 3) ? 1 : x;
    end
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock and sample at the falling edge; watch line/frame pulses as we go.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mon_en && line_start) begin
      if (last_ls >= 0) check("line_period", cyc - last_ls, 910);
      check($sformatf("line_phase_%0d", line_cnt), int'(phase), (line_cnt % 2) * 128);
      check($sformatf("frame_at_line_%0d", line_cnt), int'(frame_start), (line_cnt == 0) ? 1 : 0);
      last_ls = cyc;
      line_cnt++;
    end
    if (mon_en && frame_start && !line_start) check("frame_stray", 1, 0);
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic rst_pulse(input int n, input string tag);
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (n) @(negedge clk);
    check({tag, "_colour"}, int'(colour_num), 0);
    check({tag, "_phase"},  int'(phase), 0);
    check({tag, "_pix_req"}, int'(pix_req), 0);
    check({tag, "_pix_x"},  int'(pix_x), 0);
    check({tag, "_pix_y"},  int'(pix_y), 0);
    check({tag, "_line"},   int'(line_start), 0);
    check({tag, "_frame"},  int'(frame_start), 0);
    reset    = 1'b0;
    cyc      = 0;
    line_cnt = 0;
    last_ls  = -1;
    mon_en   = 1'b1;
    step();
    check({tag, "_c1_colour"}, int'(colour_num), 0);
    check({tag, "_c1_phase"},  int'(phase), 0);
    check({tag, "_c1_frame"},  int'(frame_start), 0);
    advance_to(2);
    check({tag, "_c2_frame"}, int'(frame_start), 1);
    check({tag, "_c2_line"},  int'(line_start), 1);
  endtask

  // Scoreboard over whole lines: colour and phase at the output, request/address at stage 1.
  task automatic check_lines(input int first, input int n);
    int s1, h1, v1, req;
    logic [5:0] e;
    advance_to(2 + first * 910);
    for (int l = first; l < first + n; l++) begin
      for (int hh = 0; hh < 910; hh++) exp_q.push_back(6'(exp_col(hh, l)));
      for (int hh = 0; hh < 910; hh++) begin
        e = exp_q.pop_front();
        check($sformatf("colour_v%0d_h%0d", l, hh), int'(colour_num), int'(e));
        check($sformatf("phase_v%0d_h%0d", l, hh), int'(phase), ((cyc - 2) * 64) % 256);
        s1  = cyc - 1;
        h1  = s1 % 910;
        v1  = s1 / 910;
        req = (v1 >= 40 && v1 <= 231 && h1 >= 160 && h1 <= 799) ? 1 : 0;
        check($sformatf("pix_req_v%0d_h%0d", v1, h1), int'(pix_req), req);
        if (req == 1) begin
          check($sformatf("pix_x_h%0d", h1), int'(pix_x), (h1 - 160) / 4);
          check($sformatf("pix_y_v%0d", v1), int'(pix_y), v1 - 40);
        end
        step();
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    rst_pulse(3, "rst0");
    check_lines(0, 1);
    check_lines(3, 4);
    check_lines(40, 1);
    // Mid-frame reset with the counters at h=500, v=41; one clock of reset.
    advance_to(41 * 910 + 500);
    rst_pulse(1, "rst_mid");
    check_lines(0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
